// File: rtl/seg7_rx_decode.sv
// Seven-segment receive decoder: per-digit debounce, hex decode, one-deep event slot, shadow values.
// Optional macro SEG7RX_DP_EN includes the decimal point (seg_n[0]) in compares and out_dp.
module seg7_rx_decode #(
  parameter int NDIG   = 8,
  parameter int STABLE = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    seg_vld,
  input  logic [$clog2(NDIG)-1:0] dig_sel,
  input  logic [7:0]              seg_n,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [$clog2(NDIG)-1:0] out_dig,
  output logic [3:0]              out_val,
  output logic                    out_dp,
  output logic                    out_err,
  output logic                    out_blank,
  output logic                    ovf,
  output logic [4*NDIG-1:0]       val_flat
);
  localparam int DW = $clog2(NDIG);
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] STB    = CW'(STABLE);
  localparam logic [DW:0]   NDIG_W = (DW + 1)'(NDIG);

  // Tuple layout: {val[3:0], dp, err, blank}
  logic [7:0]    cand_q  [NDIG];
  logic [7:0]    cand_d  [NDIG];
  logic [CW-1:0] cnt_q   [NDIG];
  logic [CW-1:0] cnt_d   [NDIG];
  logic [6:0]    shad_q  [NDIG];
  logic [6:0]    shad_d  [NDIG];
  logic [NDIG-1:0] known_q, known_d;
  logic          out_vld_q, out_vld_d;
  logic [DW-1:0] out_dig_q, out_dig_d;
  logic [6:0]    out_tup_q, out_tup_d;
  logic          ovf_q, ovf_d;

  logic [7:0] samp;
  logic [6:0] tup;
  logic       accept, confirm, fire;

`ifdef SEG7RX_DP_EN
  assign samp = seg_n;
`else
  assign samp = {seg_n[7:1], 1'b1};
`endif

  function automatic logic [6:0] decode(input logic [7:0] s);
    logic [6:0] a;
    logic [3:0] v;
    logic       e, b;
    a = ~s[7:1];
    v = 4'd0;
    e = 1'b0;
    b = 1'b0;
    case (a)
      7'h7E: v = 4'h0;  7'h30: v = 4'h1;  7'h6D: v = 4'h2;  7'h79: v = 4'h3;
      7'h33: v = 4'h4;  7'h5B: v = 4'h5;  7'h5F: v = 4'h6;  7'h70: v = 4'h7;
      7'h7F: v = 4'h8;  7'h7B: v = 4'h9;  7'h77: v = 4'hA;  7'h1F: v = 4'hB;
      7'h4E: v = 4'hC;  7'h3D: v = 4'hD;  7'h4F: v = 4'hE;  7'h47: v = 4'hF;
      7'h00: b = 1'b1;
      default: e = 1'b1;
    endcase
    return {v, ~s[0], e, b};
  endfunction

  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    shad_d    = shad_q;
    known_d   = known_q;
    out_vld_d = out_vld_q;
    out_dig_d = out_dig_q;
    out_tup_d = out_tup_q;
    ovf_d     = ovf_q;
    confirm   = 1'b0;
    tup       = decode(samp);
    accept    = seg_vld && ({1'b0, dig_sel} < NDIG_W);
    fire      = out_vld_q & out_rdy;

    if (accept) begin
      if (samp == cand_q[dig_sel]) begin
        if (cnt_q[dig_sel] != STB) begin
          cnt_d[dig_sel] = cnt_q[dig_sel] + 1'b1;
          confirm        = (cnt_q[dig_sel] == STB - 1'b1);
        end
      end else begin
        cand_d[dig_sel] = samp;
        cnt_d[dig_sel]  = CW'(1);
        confirm         = (STABLE == 1);
      end
    end

    if (fire) out_vld_d = 1'b0;

    // Shadow tracks every confirmed change even when the event itself is dropped.
    if (confirm && (!known_q[dig_sel] || tup != shad_q[dig_sel])) begin
      shad_d[dig_sel]  = tup;
      known_d[dig_sel] = 1'b1;
      if (!out_vld_q || fire) begin
        out_vld_d = 1'b1;
        out_dig_d = dig_sel;
        out_tup_d = tup;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NDIG; k++) begin
        cand_q[k] <= 8'hFF;
        cnt_q[k]  <= '0;
        shad_q[k] <= '0;
      end
      known_q   <= '0;
      out_vld_q <= 1'b0;
      out_dig_q <= '0;
      out_tup_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      shad_q    <= shad_d;
      known_q   <= known_d;
      out_vld_q <= out_vld_d;
      out_dig_q <= out_dig_d;
      out_tup_q <= out_tup_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    val_flat = '0;
    for (int k = 0; k < NDIG; k++) val_flat[4*k +: 4] = shad_q[k][6:3];
  end

  assign out_vld   = out_vld_q;
  assign out_dig   = out_dig_q;
  assign out_val   = out_tup_q[6:3];
  assign out_err   = out_tup_q[1];
  assign out_blank = out_tup_q[0];
  assign ovf       = ovf_q;
`ifdef SEG7RX_DP_EN
  assign out_dp    = out_tup_q[2];
`else
  assign out_dp    = 1'b0;
`endif

endmodule
